// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so that
// words can be sent back to back. Framing strobes mark the first and last bit.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sout;
  logic             r_sout_vld;
  logic             r_sout_first;
  logic             r_sout_last;

  logic             w_accept;
  logic             w_last_edge;
  logic             w_load_new;
  logic             w_load_hold;
  logic             w_start;
  logic [WIDTH-1:0] w_word;

  // Bit that leaves first from a word aligned in the shift register.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign w_accept    = load_valid && !r_hold_full;
  assign w_last_edge = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH));
  assign w_load_hold = w_last_edge && r_hold_full;
  assign w_load_new  = w_accept && ((r_state == IDLE) || w_last_edge);
  assign w_start     = w_load_new || w_load_hold;
  assign w_word      = w_load_hold ? r_hold : data_in;

  // Control and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold_full  <= 1'b0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_vld   <= 1'b0;
      r_sout_first <= 1'b0;
      r_sout_last  <= 1'b0;
    end else if (w_start) begin
      r_state      <= SHIFT;
      r_cnt        <= CNT_W'(1);
      r_sout       <= lead_bit(w_word);
      r_sout_vld   <= 1'b1;
      r_sout_first <= 1'b1;
      r_sout_last  <= 1'b0;
      if (w_load_hold) r_hold_full <= 1'b0;
    end else if (r_state == SHIFT && !w_last_edge) begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_sout       <= lead_bit(r_shift);
      r_sout_first <= 1'b0;
      r_sout_last  <= ((r_cnt + CNT_W'(1)) == CNT_W'(WIDTH));
      if (w_accept) r_hold_full <= 1'b1;
    end else if (r_state == SHIFT) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_vld   <= 1'b0;
      r_sout_first <= 1'b0;
      r_sout_last  <= 1'b0;
    end
  end

  // Word datapath: the shift register always holds the bits not yet driven.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_shift <= advance(w_word);
    end else if (r_state == SHIFT) begin
      r_shift <= advance(r_shift);
    end
    if (r_state == SHIFT && !w_last_edge && w_accept) begin
      r_hold <= data_in;
    end
  end

  assign load_ready = !r_hold_full;
  assign busy       = (r_state == SHIFT) || r_hold_full;
  assign sout       = r_sout;
  assign sout_valid = r_sout_vld;
  assign sout_first = r_sout_first;
  assign sout_last  = r_sout_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready, sout, sout_valid, sout_first, sout_last, busy;

  logic         l_rst;
  logic [7:0]   l_data_in;
  logic         l_load_valid;
  logic         l_load_ready, l_sout, l_sout_valid, l_sout_first, l_sout_last, l_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
    .sout_first(sout_first), .sout_last(sout_last), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(l_rst), .data_in(l_data_in), .load_valid(l_load_valid),
    .load_ready(l_load_ready), .sout(l_sout), .sout_valid(l_sout_valid),
    .sout_first(l_sout_first), .sout_last(l_sout_last), .busy(l_busy)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word appends its bits (with first/last
  // flags) to a queue; one entry is presented per clock while any remain.
  // A word is waiting in the buffer whenever a full word's worth of bits is
  // still queued behind the one on the wire.
  typedef logic [2:0] ent_t;  // {bit, first, last}
  ent_t q[$];
  ent_t m_ent;
  logic e_sout, e_valid, e_first, e_last, e_ready;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        {e_sout, e_valid, e_first, e_last} = 4'b0;
        e_ready = 1'b1;
      end else begin
        if (load_valid && e_ready)
          for (int i = 0; i < W; i++)
            q.push_back({data_in[W-1-i], (i == 0), (i == W-1)});
        if (q.size() > 0) begin
          m_ent   = q.pop_front();
          e_sout  = m_ent[2];
          e_first = m_ent[1];
          e_last  = m_ent[0];
          e_valid = 1'b1;
        end else begin
          {e_sout, e_valid, e_first, e_last} = 4'b0;
        end
        e_ready = (q.size() < W);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("m_sout_valid", sout_valid, e_valid);
        cmp("m_sout", sout, e_sout);
        cmp("m_sout_first", sout_first, e_first);
        cmp("m_sout_last", sout_last, e_last);
        cmp("m_load_ready", load_ready, e_ready);
        cmp("m_busy", busy, e_valid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  bits8;
  logic [3:0]  bits4;
  logic [13:0] vmask;
  logic [W-1:0] wds [3];
  int idx;
  logic acc;

  initial begin
    rst = 1'b1; l_rst = 1'b1;
    load_valid = 1'b0; data_in = '0;
    l_load_valid = 1'b0; l_data_in = '0;
    step();
    chk_en = 1'b1;
    cmp("rst_sout_valid", sout_valid, 1'b0);
    cmp("rst_sout", sout, 1'b0);
    cmp("rst_first_last", {sout_first, sout_last}, 2'b00);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_load_ready", load_ready, 1'b1);
    rst = 1'b0; l_rst = 1'b0;
    step();

    // Single word 1011
    load_valid = 1'b1; data_in = 4'b1011;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bits4[4-c] = sout;
      cmp("t1_first", sout_first, (c == 1));
      cmp("t1_last", sout_last, (c == 4));
      step();
    end
    cmp("t1_bits", bits4, 4'b1011);
    cmp("t1_idle_valid", sout_valid, 1'b0);
    cmp("t1_idle_busy", busy, 1'b0);

    // Back-to-back through the holding buffer
    load_valid = 1'b1; data_in = 4'b1011;
    step();
    for (int c = 1; c <= 8; c++) begin
      load_valid = (c == 2);
      if (c == 2) data_in = 4'b0110;
      bits8[8-c] = sout;
      if (c == 3 || c == 4) cmp("t2_ready_low", load_ready, 1'b0);
      if (c == 5) cmp("t2_ready_back", load_ready, 1'b1);
      if (c == 1 || c == 5) cmp("t2_first", sout_first, 1'b1);
      if (c == 4 || c == 8) cmp("t2_last", sout_last, 1'b1);
      step();
    end
    load_valid = 1'b0;
    cmp("t2_bits", bits8, 8'b10110110);
    cmp("t2_idle_valid", sout_valid, 1'b0);

    // Direct load on the last-bit edge
    load_valid = 1'b1; data_in = 4'b1100;
    step();
    for (int c = 1; c <= 8; c++) begin
      load_valid = (c == 4);
      if (c == 4) data_in = 4'b0011;
      bits8[8-c] = sout;
      cmp("t3_ready", load_ready, 1'b1);
      step();
    end
    load_valid = 1'b0;
    cmp("t3_bits", bits8, 8'b11000011);

    // Backpressure with load_valid held high
    for (int i = 0; i < 3; i++) wds[i] = W'($urandom);
    idx = 0;
    load_valid = 1'b1; data_in = wds[0];
    for (int c = 1; c <= 14; c++) begin
      acc = load_valid && load_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) data_in = wds[idx];
        else load_valid = 1'b0;
      end
      vmask[c-1] = sout_valid;
    end
    load_valid = 1'b0;
    cmp("t4_accepts", idx, 3);
    cmp("t4_gapless", vmask, 14'h0FFF);

    // Reset mid-word
    load_valid = 1'b1; data_in = 4'b1111;
    step();
    load_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    cmp("t5_outs", {sout, sout_valid, sout_first, sout_last, busy}, 5'b0);
    cmp("t5_ready", load_ready, 1'b1);
    rst = 1'b0;
    step();
    load_valid = 1'b1; data_in = 4'b0101;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bits4[4-c] = sout;
      step();
    end
    cmp("t5_bits", bits4, 4'b0101);

    // LSB-first, 8-bit build
    l_load_valid = 1'b1; l_data_in = 8'hA5;
    step();
    l_load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bits8[c-1] = l_sout;
      cmp("t6_valid", l_sout_valid, 1'b1);
      cmp("t6_last", l_sout_last, (c == 8));
      step();
    end
    cmp("t6_bits", bits8, 8'hA5);
    cmp("t6_idle_valid", l_sout_valid, 1'b0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      data_in = W'($urandom);
      step();
    end
    rst = 1'b0; load_valid = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
